sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 33 +++
 rtl/sram_arbiter_grant.sv | 27 ++
 rtl/sram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and widths for the SRAM arbiter (fetch port vs. load/store port).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NUM_OF_BYTES
`define NUM_OF_BYTES 4
`endif

package sram_arbiter_pkg;

   localparam int ADDR_W = `ADDR_WIDTH;
   localparam int DATA_W = `DATA_WIDTH;
   localparam int MASK_W = `NUM_OF_BYTES;

   // Bit positions inside the one-hot grant vector
   localparam int GNT_IF  = 0;
   localparam int GNT_MEM = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/sram_arbiter_grant.sv
// Two-requester grant: a lone requester wins; on contention the side that was not
// granted last wins. Tying last_grant to OWN_IF gives fixed MEM-over-IF priority.
module sram_arb_grant
   import sram_arbiter_pkg::*;
(
   input  logic       if_valid,
   input  logic       mem_valid,
   input  arb_owner_t last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (if_valid && mem_valid) begin
         if (last_grant == OWN_MEM) begin
            grant[GNT_IF] = 1'b1;
         end else begin
            grant[GNT_MEM] = 1'b1;
         end
      end else if (mem_valid) begin
         grant[GNT_MEM] = 1'b1;
      end else if (if_valid) begin
         grant[GNT_IF] = 1'b1;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Single-outstanding arbiter between a fetch port and a load/store port onto one SRAM.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin contention; default is MEM-over-IF priority.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned RESP_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_resp_valid,
   output logic [DATA_W-1:0] if_resp_data,

   input  logic              mem_req_valid,
   output logic              mem_req_ready,
   input  logic              mem_req_we,
   input  logic [ADDR_W-1:0] mem_req_addr,
   input  logic [DATA_W-1:0] mem_req_wdata,
   input  logic [MASK_W-1:0] mem_req_mask,
   output logic              mem_resp_valid,
   output logic [DATA_W-1:0] mem_resp_data,

   output logic              ram_req_valid,
   output logic              ram_req_we,
   output logic [ADDR_W-1:0] ram_req_addr,
   output logic [DATA_W-1:0] ram_req_wdata,
   output logic [MASK_W-1:0] ram_req_mask,
   input  logic              ram_req_ready,
   input  logic              ram_resp_valid,
   input  logic [DATA_W-1:0] ram_resp_data,

   output logic              err_timeout
);

   arb_state_t        state, state_next;
   arb_owner_t        hold_owner;
   logic [ADDR_W-1:0] hold_addr;
   logic              hold_we;
   logic [DATA_W-1:0] hold_wdata;
   logic [MASK_W-1:0] hold_mask;
   logic [7:0]        counter;
   logic [1:0]        grant;
   arb_owner_t        last_grant;
   logic              handshake;
   logic              timeout_hit;
   logic              resp_fire;
   logic [DATA_W-1:0] resp_data;

   sram_arb_grant u_grant (
      .if_valid   (if_req_valid),
      .mem_valid  (mem_req_valid),
      .last_grant (last_grant),
      .grant      (grant)
   );

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= OWN_MEM;
      end else if (handshake) begin
         last_grant <= grant[GNT_MEM] ? OWN_MEM : OWN_IF;
      end
   end
`else
   // Pretending IF was granted last makes every contention go to MEM
   assign last_grant = OWN_IF;
`endif

   assign handshake   = (state == ST_IDLE) && (grant != 2'b00);
   assign timeout_hit = (counter == 8'(RESP_TIMEOUT - 1));

   assign ram_req_we    = hold_we;
   assign ram_req_addr  = hold_addr;
   assign ram_req_wdata = hold_wdata;
   assign ram_req_mask  = hold_mask;

   always_comb begin
      state_next    = state;
      if_req_ready  = 1'b0;
      mem_req_ready = 1'b0;
      ram_req_valid = 1'b0;
      err_timeout   = 1'b0;
      resp_fire     = 1'b0;
      resp_data     = '0;
      case (state)
         ST_IDLE: begin
            if_req_ready  = grant[GNT_IF];
            mem_req_ready = grant[GNT_MEM];
            if (handshake) begin
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            ram_req_valid = 1'b1;
            if (ram_req_ready) begin
               if (hold_we) begin
                  resp_fire  = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (ram_resp_valid) begin
               resp_fire  = 1'b1;
               resp_data  = ram_resp_data;
               state_next = ST_IDLE;
            end else if (timeout_hit) begin
               resp_fire   = 1'b1;
               err_timeout = 1'b1;
               state_next  = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      if_resp_valid  = 1'b0;
      if_resp_data   = '0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      if (hold_owner == OWN_IF) begin
         if_resp_valid = resp_fire;
         if_resp_data  = resp_data;
      end else begin
         mem_resp_valid = resp_fire;
         mem_resp_data  = resp_data;
      end
   end

   // Hold registers capture the winner so requesters are free once accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         hold_owner <= OWN_IF;
         hold_addr  <= '0;
         hold_we    <= 1'b0;
         hold_wdata <= '0;
         hold_mask  <= '0;
         counter    <= '0;
      end else begin
         state <= state_next;
         if (handshake) begin
            if (grant[GNT_MEM]) begin
               hold_owner <= OWN_MEM;
               hold_addr  <= mem_req_addr;
               hold_we    <= mem_req_we;
               hold_wdata <= mem_req_wdata;
               hold_mask  <= mem_req_mask;
            end else begin
               hold_owner <= OWN_IF;
               hold_addr  <= if_req_addr;
               hold_we    <= 1'b0;
               hold_wdata <= '0;
               hold_mask  <= '0;
            end
         end
         if (state == ST_ISSUE) begin
            counter <= '0;
         end else if (state == ST_WAIT) begin
            counter <= counter + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a transaction-level model of grants,
// SRAM contents and response timing. Honours SRAM_ARB_ROUND_ROBIN_EN.
module tb_sram_arbiter;

   localparam int T = 8;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_valid, if_req_ready, if_resp_valid;
   logic [31:0] if_req_addr, if_resp_data;
   logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
   logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
   logic [3:0]  mem_req_mask;
   logic        ram_req_valid, ram_req_we, ram_req_ready, ram_resp_valid;
   logic [31:0] ram_req_addr, ram_req_wdata, ram_resp_data;
   logic [3:0]  ram_req_mask;
   logic        err_timeout;

   int tests = 0;
   int fails = 0;

   logic [31:0] sram [logic [31:0]];
   bit          last_was_mem;

   always #5 clk = ~clk;

   sram_arbiter #(.RESP_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_mask(mem_req_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .ram_req_valid(ram_req_valid), .ram_req_we(ram_req_we), .ram_req_addr(ram_req_addr),
      .ram_req_wdata(ram_req_wdata), .ram_req_mask(ram_req_mask), .ram_req_ready(ram_req_ready),
      .ram_resp_valid(ram_resp_valid), .ram_resp_data(ram_resp_data),
      .err_timeout(err_timeout)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] sramRead(input logic [31:0] addr);
      if (sram.exists(addr)) return sram[addr];
      return addr ^ 32'h5EED_0000;
   endfunction

   task automatic idleInputs();
      if_req_valid   = 1'b0;
      if_req_addr    = '0;
      mem_req_valid  = 1'b0;
      mem_req_we     = 1'b0;
      mem_req_addr   = '0;
      mem_req_wdata  = '0;
      mem_req_mask   = '0;
      ram_req_ready  = 1'b0;
      ram_resp_valid = 1'b0;
      ram_resp_data  = '0;
   endtask

   task automatic scrambleRequesters();
      if_req_valid  = 1'($urandom_range(0, 1));
      if_req_addr   = $urandom();
      mem_req_valid = 1'($urandom_range(0, 1));
      mem_req_we    = 1'($urandom_range(0, 1));
      mem_req_addr  = $urandom();
      mem_req_wdata = $urandom();
      mem_req_mask  = 4'($urandom());
   endtask

   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One full transaction starting at a negedge with the arbiter idle
   task automatic applyStimulus(input bit want_if, input bit want_mem,
                                input logic [31:0] i_addr, input logic [31:0] m_addr,
                                input logic m_we, input logic [31:0] m_wdata, input logic [3:0] m_mask,
                                input int rdy_delay, input int resp_delay);
      bit          win_mem;
      logic [31:0] e_addr, e_wdata, old_word, new_word, rd_word;
      logic        e_we;
      logic [3:0]  e_mask;
      bit          done;
      win_mem = (want_if && want_mem) ? (RR_EN ? !last_was_mem : 1'b1) : want_mem;
      e_addr  = win_mem ? m_addr : i_addr;
      e_we    = win_mem ? m_we : 1'b0;
      e_wdata = m_wdata;
      e_mask  = win_mem ? m_mask : 4'b0000;

      idleInputs();
      if_req_valid  = want_if;
      if_req_addr   = i_addr;
      mem_req_valid = want_mem;
      mem_req_we    = m_we;
      mem_req_addr  = m_addr;
      mem_req_wdata = m_wdata;
      mem_req_mask  = m_mask;
      #1;
      checkOutput("if_req_ready", if_req_ready, !win_mem);
      checkOutput("mem_req_ready", mem_req_ready, win_mem);
      last_was_mem = win_mem;
      nextCycle();

      for (int i = 0; i <= rdy_delay; i++) begin
         scrambleRequesters();
         ram_req_ready  = (i == rdy_delay);
         ram_resp_valid = 1'($urandom_range(0, 1));
         ram_resp_data  = $urandom();
         #1;
         checkOutput("issue_valid", ram_req_valid, 1);
         checkOutput("issue_addr", ram_req_addr, e_addr);
         checkOutput("issue_we", ram_req_we, e_we);
         checkOutput("issue_mask", ram_req_mask, e_mask);
         if (e_we) checkOutput("issue_wdata", ram_req_wdata, e_wdata);
         checkOutput("issue_no_ready", {if_req_ready, mem_req_ready}, 0);
         checkOutput("issue_store_ack", mem_resp_valid, e_we && (i == rdy_delay));
         checkOutput("issue_no_if_resp", if_resp_valid, 0);
         if (e_we && i == rdy_delay) begin
            checkOutput("store_ack_data", mem_resp_data, 0);
            old_word = sramRead(e_addr);
            new_word = old_word;
            for (int b = 0; b < 4; b++)
               if (e_mask[b]) new_word[8*b +: 8] = e_wdata[8*b +: 8];
            sram[e_addr] = new_word;
         end
         nextCycle();
      end
      ram_req_ready  = 1'b0;
      ram_resp_valid = 1'b0;

      if (!e_we) begin
         done = 1'b0;
         for (int k = 1; k <= T && !done; k++) begin
            scrambleRequesters();
            ram_resp_valid = (k == resp_delay);
            rd_word        = sramRead(e_addr);
            ram_resp_data  = (k == resp_delay) ? rd_word : $urandom();
            done           = (k == resp_delay) || (k == T);
            #1;
            checkOutput("wait_owner_valid", win_mem ? mem_resp_valid : if_resp_valid, done);
            checkOutput("wait_other_valid", win_mem ? if_resp_valid : mem_resp_valid, 0);
            checkOutput("wait_err", err_timeout, (k == T) && (k != resp_delay));
            checkOutput("wait_no_ready", {if_req_ready, mem_req_ready, ram_req_valid}, 0);
            if (done)
               checkOutput("read_data", win_mem ? mem_resp_data : if_resp_data,
                           (k == resp_delay) ? rd_word : 32'h0);
            nextCycle();
         end
         if (resp_delay > T) begin
            idleInputs();
            ram_resp_valid = 1'b1;
            ram_resp_data  = $urandom();
            #1;
            checkOutput("late_resp_ignored", {if_resp_valid, mem_resp_valid, err_timeout}, 0);
            nextCycle();
         end
      end
      idleInputs();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit          a, b, we;
      logic [31:0] ia, ma;
      idleInputs();
      rst = 1'b1;
      last_was_mem = 1'b1;
      @(negedge clk);
      nextCycle();
      #1;
      checkOutput("rst_readies", {if_req_ready, mem_req_ready}, 0);
      checkOutput("rst_ram_valid", ram_req_valid, 0);
      checkOutput("rst_hold_addr", ram_req_addr, 0);
      checkOutput("rst_resp", {if_resp_valid, mem_resp_valid, err_timeout}, 0);
      @(negedge clk);
      rst = 1'b0;

      sram[32'h1C00_0000] = 32'h1234_5678;
      applyStimulus(1, 0, 32'h1C00_0000, 32'h0, 0, 32'h0, 4'h0, 0, 1);
      applyStimulus(0, 1, 32'h0, 32'h100, 1, 32'hAABB_CCDD, 4'b0011, 3, 0);
      applyStimulus(0, 1, 32'h0, 32'h100, 0, 32'h0, 4'h0, 0, 1);
      applyStimulus(1, 0, 32'h200, 32'h0, 0, 32'h0, 4'h0, 1, T + 2);
      applyStimulus(0, 1, 32'h0, 32'h300, 0, 32'h0, 4'h0, 0, T);

      for (int n = 0; n < 6; n++)
         applyStimulus(1, 1, 32'(n) << 2, 32'h40 + (32'(n) << 2), 0, 32'h0, 4'h0, 0, 1);

      for (int n = 0; n < 60; n++) begin
         a  = 1'($urandom_range(0, 1));
         b  = 1'($urandom_range(0, 1));
         if (!a && !b) b = 1'b1;
         we = 1'($urandom_range(0, 1));
         ia = 32'($urandom_range(0, 15)) << 2;
         ma = 32'($urandom_range(0, 15)) << 2;
         applyStimulus(a, b, ia, ma, we, $urandom(), 4'($urandom()),
                       $urandom_range(0, 3), $urandom_range(1, T + 2));
      end

      // Reset while a load sits in WAIT
      mem_req_valid = 1'b1;
      mem_req_we    = 1'b0;
      mem_req_addr  = 32'h40;
      #1;
      checkOutput("rstw_hs", mem_req_ready, !if_req_valid);
      nextCycle();
      mem_req_valid = 1'b0;
      ram_req_ready = 1'b1;
      nextCycle();
      ram_req_ready = 1'b0;
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      ram_resp_valid = 1'b1;
      ram_resp_data  = 32'hCAFE_F00D;
      #1;
      checkOutput("rstw_no_resp", {if_resp_valid, mem_resp_valid, err_timeout}, 0);
      checkOutput("rstw_no_ram_req", ram_req_valid, 0);
      ram_resp_valid = 1'b0;
      last_was_mem = 1'b1;
      applyStimulus(1, 1, 32'h80, 32'h84, 0, 32'h0, 4'h0, 0, 2);
      applyStimulus(1, 1, 32'h88, 32'h8C, 0, 32'h0, 4'h0, 1, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
